id_stage_pipe: RTL and testbench
================================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter FWD_EN, default 1, 1 = EX/MEM forwarding enabled, 0 = regfile data only.
REQ-003 SHALL have ports: clk in 1 clock; rst in 1 reset. One clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports: if_valid in 1; if_ready out 1; if_pc in 16; if_inst in 16 (instruction handshake from IF).
REQ-005 SHALL have ports: reg1_read, reg2_read out 1; reg1_read_addr, reg2_read_addr out 4; reg1_data_in, reg2_data_in in DATA_W (combinational regfile ports).
REQ-006 SHALL have ports: ex_wreg in 1, ex_wd in 4, ex_wdata in DATA_W, ex_is_load in 1; mem_wreg in 1, mem_wd in 4, mem_wdata in DATA_W (writeback info of instructions ahead).
REQ-007 SHALL have ports: flush in 1 (kill decode stage).
REQ-008 SHALL have ports: id_valid out 1; id_ready in 1; id_pc out 16; aluop out 8; alusel out 3; reg1_data_out, reg2_data_out out DATA_W; wd_o out 4; wreg_o out 1; illegal_o out 1; is_load_o out 1.

Function
REQ-009 SHALL decode opcode=if_inst[15:10], rs1=if_inst[9:6], rs2=if_inst[5:2]; reg1_read_addr=rs1, reg2_read_addr=rs2 always (combinational).
REQ-010 SHALL decode opcode 0x00: NOP, no reads, wreg=0, aluop=0, alusel=0.
REQ-011 SHALL decode 0x01-0x0F: reg-reg ALU; reads rs1,rs2; aluop={2'b00,opcode}; alusel=1; wd=rs1; wreg=1.
REQ-012 SHALL decode 0x10-0x1F: reg-imm ALU; reads rs1 only; operand2 = sign-extended if_inst[5:0] to DATA_W; aluop={2'b00,opcode}; alusel=2; wd=rs1; wreg=1.
REQ-013 SHALL decode 0x20: load; reads rs2 (address); operand1=0; aluop=0x20; alusel=3; wd=rs1; wreg=1; is_load=1.
REQ-014 SHALL decode all other opcodes: illegal; no reads, wreg=0, aluop=0, alusel=0, illegal=1; still issued as a slot.
REQ-015 SHALL select each read operand (FWD_EN=1) by priority: ex_wreg && ex_wd==addr -> ex_wdata; else mem_wreg && mem_wd==addr -> mem_wdata; else regfile data; FWD_EN=0 -> regfile only.
REQ-016 SHALL detect load-use hazard: ex_is_load && ex_wreg && ex_wd matches an operand actually read by the current if_inst.
REQ-017 SHALL compute stall = if_valid && hazard; if_ready = (!id_valid || id_ready) && !hazard.
REQ-018 SHALL capture decoded fields, operands, if_pc into output register on rising clk when if_valid && if_ready; id_valid<=1.
REQ-019 SHALL, when output slot free (!id_valid || id_ready) and no capture (hazard or !if_valid), set id_valid<=0 (bubble).
REQ-020 SHALL hold all output registers stable while id_valid && !id_ready.
REQ-021 SHALL, when flush=1, set id_valid<=0 and deassert if_ready that cycle; flush overrides capture, hold and hazard.
REQ-022 SHALL provide decode-to-output latency of exactly one clk; throughput one instruction/cycle without hazard or backpressure.
REQ-023 SHALL treat reg reads with read-enable 0 as non-matching for forwarding and hazard.

Reset
REQ-024 SHALL, while rst=1 (asynchronously), force id_valid=0, id_pc=0, aluop=0, alusel=0, reg1_data_out=0, reg2_data_out=0, wd_o=0, wreg_o=0, illegal_o=0, is_load_o=0.
REQ-025 SHALL, while rst=1, drive if_ready=0, reg1_read=0, reg2_read=0, reg1_read_addr=0, reg2_read_addr=0.
REQ-026 SHALL, with rst asserted mid-transaction, discard the held instruction; first post-reset capture occurs on first clk edge with rst=0.

Verification
REQ-027 SHALL test reg-reg: if_inst=0x0454 (op 1, rs1=1, rs2=5), regs r1=3, r5=4, id_ready=1 -> next cycle id_valid=1, aluop=0x01, alusel=1, data 3/4, wd_o=1, wreg_o=1.
REQ-028 SHALL test imm sign-extend: op 0x10, imm 6'b111110 -> reg2_data_out=0xFFFFFFFE (DATA_W=32).
REQ-029 SHALL test forwarding priority: ex_wd=mem_wd=rs1=2, ex_wdata=0xA, mem_wdata=0xB -> reg1_data_out=0xA; FWD_EN=0 -> regfile value.
REQ-030 SHALL test load-use: ex_is_load=1, ex_wd=rs2 -> if_ready=0 one cycle, id_valid=0 bubble, then instruction issues.
REQ-031 SHALL test backpressure: id_ready=0 for 3 cycles -> outputs unchanged, if_ready=0; flush during stall -> id_valid=0 next cycle.
REQ-032 SHALL test illegal opcode 0x3F -> id_valid=1, illegal_o=1, wreg_o=0; async rst mid-stall -> id_valid=0 immediately.

Source files
------------

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - instruction decode stage with operand forwarding and load-use stall
//
// Purpose: decodes a 16-bit instruction from IF, reads the register file
// combinationally, forwards results of instructions still in EX/MEM, and
// registers the decoded slot toward EX with a valid/ready handshake.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_valid/if_ready/if_pc/if_inst   instruction handshake from IF
//   reg{1,2}_read, reg{1,2}_read_addr, reg{1,2}_data_in   regfile read ports
//   ex_wreg/ex_wd/ex_wdata/ex_is_load, mem_wreg/mem_wd/mem_wdata   writeback info ahead
//   flush                         kill the decode stage
//   id_valid/id_ready/id_pc, aluop, alusel, reg{1,2}_data_out,
//   wd_o, wreg_o, illegal_o, is_load_o   registered decoded slot toward EX

module id_stage_pipe #(
   parameter int DATA_W = 32,
   parameter int FWD_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [15:0]       if_pc,
   input  logic [15:0]       if_inst,
   output logic              reg1_read,
   output logic              reg2_read,
   output logic [3:0]        reg1_read_addr,
   output logic [3:0]        reg2_read_addr,
   input  logic [DATA_W-1:0] reg1_data_in,
   input  logic [DATA_W-1:0] reg2_data_in,
   input  logic              ex_wreg,
   input  logic [3:0]        ex_wd,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic              ex_is_load,
   input  logic              mem_wreg,
   input  logic [3:0]        mem_wd,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              flush,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [15:0]       id_pc,
   output logic [7:0]        aluop,
   output logic [2:0]        alusel,
   output logic [DATA_W-1:0] reg1_data_out,
   output logic [DATA_W-1:0] reg2_data_out,
   output logic [3:0]        wd_o,
   output logic              wreg_o,
   output logic              illegal_o,
   output logic              is_load_o
);

   logic [5:0]        op;
   logic [3:0]        rs1, rs2;
   logic              rd1_en, rd2_en;
   logic [7:0]        dec_aluop;
   logic [2:0]        dec_alusel;
   logic [3:0]        dec_wd;
   logic              dec_wreg, dec_illegal, dec_load;
   logic              use_imm, op1_zero;
   logic [DATA_W-1:0] fwd1, fwd2, op1, op2;
   logic              hazard, slot_free, capture;

   logic              id_valid_q, id_valid_d;
   logic [15:0]       id_pc_q, id_pc_d;
   logic [7:0]        aluop_q, aluop_d;
   logic [2:0]        alusel_q, alusel_d;
   logic [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d;
   logic [3:0]        wd_q, wd_d;
   logic              wreg_q, wreg_d, illegal_q, illegal_d, is_load_q, is_load_d;

   assign op  = if_inst[15:10];
   assign rs1 = if_inst[9:6];
   assign rs2 = if_inst[5:2];

   always_comb begin
      rd1_en      = 1'b0;
      rd2_en      = 1'b0;
      dec_aluop   = 8'h00;
      dec_alusel  = 3'd0;
      dec_wd      = 4'd0;
      dec_wreg    = 1'b0;
      dec_illegal = 1'b0;
      dec_load    = 1'b0;
      use_imm     = 1'b0;
      op1_zero    = 1'b0;
      if (op == 6'h00) begin
         // NOP: everything stays at its default
      end else if (op <= 6'h0F) begin
         rd1_en = 1'b1; rd2_en = 1'b1;
         dec_aluop = {2'b00, op}; dec_alusel = 3'd1; dec_wd = rs1; dec_wreg = 1'b1;
      end else if (op <= 6'h1F) begin
         rd1_en = 1'b1; use_imm = 1'b1;
         dec_aluop = {2'b00, op}; dec_alusel = 3'd2; dec_wd = rs1; dec_wreg = 1'b1;
      end else if (op == 6'h20) begin
         // load: address comes from rs2, rs1 names the destination
         rd2_en = 1'b1; op1_zero = 1'b1;
         dec_aluop = 8'h20; dec_alusel = 3'd3; dec_wd = rs1; dec_wreg = 1'b1; dec_load = 1'b1;
      end else begin
         dec_illegal = 1'b1;
      end
   end

   // Youngest producer wins: EX result is newer than MEM result.
   always_comb begin
      fwd1 = reg1_data_in;
      fwd2 = reg2_data_in;
      if (FWD_EN != 0) begin
         if (ex_wreg && ex_wd == rs1)        fwd1 = ex_wdata;
         else if (mem_wreg && mem_wd == rs1) fwd1 = mem_wdata;
         if (ex_wreg && ex_wd == rs2)        fwd2 = ex_wdata;
         else if (mem_wreg && mem_wd == rs2) fwd2 = mem_wdata;
      end
      op1 = op1_zero ? '0 : fwd1;
      op2 = use_imm ? {{(DATA_W-6){if_inst[5]}}, if_inst[5:0]} : fwd2;
   end

   // A load in EX has no data yet; only operands really read can collide.
   assign hazard = ex_is_load && ex_wreg &&
                   ((rd1_en && ex_wd == rs1) || (rd2_en && ex_wd == rs2));
   assign slot_free = !id_valid_q || id_ready;
   assign if_ready  = !rst && !flush && slot_free && !hazard;
   assign capture   = if_valid && if_ready;

   assign reg1_read      = !rst && rd1_en;
   assign reg2_read      = !rst && rd2_en;
   assign reg1_read_addr = rst ? 4'd0 : rs1;
   assign reg2_read_addr = rst ? 4'd0 : rs2;

   always_comb begin
      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
      aluop_d    = aluop_q;
      alusel_d   = alusel_q;
      r1_d       = r1_q;
      r2_d       = r2_q;
      wd_d       = wd_q;
      wreg_d     = wreg_q;
      illegal_d  = illegal_q;
      is_load_d  = is_load_q;
      if (flush) begin
         id_valid_d = 1'b0;
      end else if (capture) begin
         id_valid_d = 1'b1;
         id_pc_d    = if_pc;
         aluop_d    = dec_aluop;
         alusel_d   = dec_alusel;
         r1_d       = op1;
         r2_d       = op2;
         wd_d       = dec_wd;
         wreg_d     = dec_wreg;
         illegal_d  = dec_illegal;
         is_load_d  = dec_load;
      end else if (slot_free) begin
         id_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid_q <= 1'b0;
         id_pc_q    <= 16'h0000;
         aluop_q    <= 8'h00;
         alusel_q   <= 3'd0;
         r1_q       <= '0;
         r2_q       <= '0;
         wd_q       <= 4'd0;
         wreg_q     <= 1'b0;
         illegal_q  <= 1'b0;
         is_load_q  <= 1'b0;
      end else begin
         id_valid_q <= id_valid_d;
         id_pc_q    <= id_pc_d;
         aluop_q    <= aluop_d;
         alusel_q   <= alusel_d;
         r1_q       <= r1_d;
         r2_q       <= r2_d;
         wd_q       <= wd_d;
         wreg_q     <= wreg_d;
         illegal_q  <= illegal_d;
         is_load_q  <= is_load_d;
      end
   end

   assign id_valid      = id_valid_q;
   assign id_pc         = id_pc_q;
   assign aluop         = aluop_q;
   assign alusel        = alusel_q;
   assign reg1_data_out = r1_q;
   assign reg2_data_out = r2_q;
   assign wd_o          = wd_q;
   assign wreg_o        = wreg_q;
   assign illegal_o     = illegal_q;
   assign is_load_o     = is_load_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed self-checking bench for id_stage_pipe
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid, id_ready, flush;
   logic [15:0] if_pc, if_inst;
   logic        ex_wreg, ex_is_load, mem_wreg;
   logic [3:0]  ex_wd, mem_wd;
   logic [31:0] ex_wdata, mem_wdata;
   logic [31:0] rf [16];

   logic        if_ready, reg1_read, reg2_read;
   logic [3:0]  reg1_read_addr, reg2_read_addr;
   logic [31:0] reg1_data_in, reg2_data_in;
   logic        id_valid;
   logic [15:0] id_pc;
   logic [7:0]  aluop;
   logic [2:0]  alusel;
   logic [31:0] reg1_data_out, reg2_data_out;
   logic [3:0]  wd_o;
   logic        wreg_o, illegal_o, is_load_o;

   logic        nf_if_ready, nf_reg1_read, nf_reg2_read;
   logic [3:0]  nf_reg1_read_addr, nf_reg2_read_addr;
   logic [31:0] nf_reg1_data_in, nf_reg2_data_in;
   logic        nf_id_valid;
   logic [15:0] nf_id_pc;
   logic [7:0]  nf_aluop;
   logic [2:0]  nf_alusel;
   logic [31:0] nf_reg1_data_out, nf_reg2_data_out;
   logic [3:0]  nf_wd_o;
   logic        nf_wreg_o, nf_illegal_o, nf_is_load_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign reg1_data_in    = rf[reg1_read_addr];
   assign reg2_data_in    = rf[reg2_read_addr];
   assign nf_reg1_data_in = rf[nf_reg1_read_addr];
   assign nf_reg2_data_in = rf[nf_reg2_read_addr];

   id_stage_pipe #(.DATA_W(32), .FWD_EN(1)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_inst(if_inst),
      .reg1_read(reg1_read), .reg2_read(reg2_read),
      .reg1_read_addr(reg1_read_addr), .reg2_read_addr(reg2_read_addr),
      .reg1_data_in(reg1_data_in), .reg2_data_in(reg2_data_in),
      .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
      .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
      .flush(flush), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
      .aluop(aluop), .alusel(alusel),
      .reg1_data_out(reg1_data_out), .reg2_data_out(reg2_data_out),
      .wd_o(wd_o), .wreg_o(wreg_o), .illegal_o(illegal_o), .is_load_o(is_load_o)
   );

   id_stage_pipe #(.DATA_W(32), .FWD_EN(0)) dut_nf (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(nf_if_ready),
      .if_pc(if_pc), .if_inst(if_inst),
      .reg1_read(nf_reg1_read), .reg2_read(nf_reg2_read),
      .reg1_read_addr(nf_reg1_read_addr), .reg2_read_addr(nf_reg2_read_addr),
      .reg1_data_in(nf_reg1_data_in), .reg2_data_in(nf_reg2_data_in),
      .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
      .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
      .flush(flush), .id_valid(nf_id_valid), .id_ready(id_ready), .id_pc(nf_id_pc),
      .aluop(nf_aluop), .alusel(nf_alusel),
      .reg1_data_out(nf_reg1_data_out), .reg2_data_out(nf_reg2_data_out),
      .wd_o(nf_wd_o), .wreg_o(nf_wreg_o), .illegal_o(nf_illegal_o), .is_load_o(nf_is_load_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] pc, input logic [15:0] inst);
      @(negedge clk);
      if_valid = 1'b1;
      if_pc    = pc;
      if_inst  = inst;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = 32'h100 + i;
      rf[1] = 32'd3;
      rf[5] = 32'd4;
      rst = 1'b1; flush = 1'b0; id_ready = 1'b1;
      if_valid = 1'b1; if_pc = 16'h0; if_inst = 16'h0454;
      ex_wreg = 1'b0; ex_wd = 4'd0; ex_wdata = 32'h0; ex_is_load = 1'b0;
      mem_wreg = 1'b0; mem_wd = 4'd0; mem_wdata = 32'h0;
      #2;
      check_eq("rst_id_valid", {31'd0, id_valid}, 32'd0);
      check_eq("rst_if_ready", {31'd0, if_ready}, 32'd0);
      check_eq("rst_rd_addr", {28'd0, reg1_read_addr}, 32'd0);
      check_eq("rst_rd_en", {31'd0, reg1_read}, 32'd0);
      check_eq("rst_r1_out", reg1_data_out, 32'd0);

      // reg-reg: op 1, rs1=1, rs2=5
      drive(16'h0100, 16'h0454);
      rst = 1'b0;
      #1;
      check_eq("rr_if_ready", {31'd0, if_ready}, 32'd1);
      check_eq("rr_rd_en", {30'd0, reg1_read, reg2_read}, 32'd3);
      tick();
      check_eq("rr_valid", {31'd0, id_valid}, 32'd1);
      check_eq("rr_pc", {16'd0, id_pc}, 32'h0100);
      check_eq("rr_aluop", {24'd0, aluop}, 32'h01);
      check_eq("rr_alusel", {29'd0, alusel}, 32'd1);
      check_eq("rr_r1", reg1_data_out, 32'd3);
      check_eq("rr_r2", reg2_data_out, 32'd4);
      check_eq("rr_wd", {28'd0, wd_o}, 32'd1);
      check_eq("rr_wreg", {31'd0, wreg_o}, 32'd1);

      // reg-imm: op 0x10, rs1=3, imm=6'b111110
      drive(16'h0102, 16'h40FE);
      #1;
      check_eq("ri_rd_en", {30'd0, reg1_read, reg2_read}, 32'd2);
      tick();
      check_eq("ri_aluop", {24'd0, aluop}, 32'h10);
      check_eq("ri_alusel", {29'd0, alusel}, 32'd2);
      check_eq("ri_r1", reg1_data_out, 32'h103);
      check_eq("ri_r2_sext", reg2_data_out, 32'hFFFFFFFE);

      // forwarding priority: op 1, rs1=2, rs2=4; EX and MEM both write r2
      drive(16'h0104, 16'h0490);
      ex_wreg = 1'b1; ex_wd = 4'd2; ex_wdata = 32'hA;
      mem_wreg = 1'b1; mem_wd = 4'd2; mem_wdata = 32'hB;
      tick();
      check_eq("fwd_ex_r1", reg1_data_out, 32'hA);
      check_eq("fwd_r2_rf", reg2_data_out, 32'h104);
      check_eq("nofwd_r1", nf_reg1_data_out, 32'h102);
      drive(16'h0106, 16'h0490);
      ex_wreg = 1'b0;
      tick();
      check_eq("fwd_mem_r1", reg1_data_out, 32'hB);

      // load-use: load in EX writes r5; reg-imm with rs2 field 5 does not read it
      drive(16'h0108, 16'h40D4);
      mem_wreg = 1'b0;
      ex_wreg = 1'b1; ex_is_load = 1'b1; ex_wd = 4'd5; ex_wdata = 32'hDEAD;
      #1;
      check_eq("lu_unread_no_haz", {31'd0, if_ready}, 32'd1);
      if_inst = 16'h81D4;  // load: rs1=7 dest, rs2=5 address
      #1;
      check_eq("lu_if_ready", {31'd0, if_ready}, 32'd0);
      tick();
      check_eq("lu_bubble", {31'd0, id_valid}, 32'd0);
      @(negedge clk);
      ex_wreg = 1'b0; ex_is_load = 1'b0;
      mem_wreg = 1'b1; mem_wd = 4'd5; mem_wdata = 32'h55;
      #1;
      check_eq("lu_if_ready_after", {31'd0, if_ready}, 32'd1);
      tick();
      check_eq("ld_valid", {31'd0, id_valid}, 32'd1);
      check_eq("ld_is_load", {31'd0, is_load_o}, 32'd1);
      check_eq("ld_r1_zero", reg1_data_out, 32'd0);
      check_eq("ld_r2_fwd", reg2_data_out, 32'h55);
      check_eq("ld_aluop", {24'd0, aluop}, 32'h20);
      check_eq("ld_alusel", {29'd0, alusel}, 32'd3);
      check_eq("ld_wd", {28'd0, wd_o}, 32'd7);

      // backpressure for 3 cycles, then flush during the stall
      drive(16'h0200, 16'h0454);
      mem_wreg = 1'b0;
      id_ready = 1'b0;
      #1;
      check_eq("bp_if_ready", {31'd0, if_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("bp_valid", {31'd0, id_valid}, 32'd1);
         check_eq("bp_pc", {16'd0, id_pc}, 32'h0108);
         check_eq("bp_aluop", {24'd0, aluop}, 32'h20);
         check_eq("bp_r2", reg2_data_out, 32'h55);
         check_eq("bp_if_ready", {31'd0, if_ready}, 32'd0);
      end
      @(negedge clk);
      flush = 1'b1;
      #1;
      check_eq("fl_if_ready", {31'd0, if_ready}, 32'd0);
      tick();
      check_eq("fl_valid", {31'd0, id_valid}, 32'd0);

      // illegal opcode 0x3F
      drive(16'h0300, 16'hFC00);
      flush = 1'b0; id_ready = 1'b1;
      tick();
      check_eq("ill_valid", {31'd0, id_valid}, 32'd1);
      check_eq("ill_flag", {31'd0, illegal_o}, 32'd1);
      check_eq("ill_wreg", {31'd0, wreg_o}, 32'd0);
      check_eq("ill_pc", {16'd0, id_pc}, 32'h0300);

      // async reset while stalled
      drive(16'h0302, 16'h0454);
      id_ready = 1'b0;
      tick();
      check_eq("st_valid", {31'd0, id_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_valid", {31'd0, id_valid}, 32'd0);
      check_eq("arst_illegal", {31'd0, illegal_o}, 32'd0);
      check_eq("arst_pc", {16'd0, id_pc}, 32'd0);
      check_eq("arst_if_ready", {31'd0, if_ready}, 32'd0);

      // first edge with rst low captures
      drive(16'h0400, 16'h0454);
      rst = 1'b0; id_ready = 1'b1;
      tick();
      check_eq("post_rst_valid", {31'd0, id_valid}, 32'd1);
      check_eq("post_rst_pc", {16'd0, id_pc}, 32'h0400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
